// File: rtl/filt_pkg.sv
// Shared definitions for the filter cascade: default sample format and accumulator sizing.
package filt_pkg;

    localparam int WI_DEF = 2;
    localparam int WF_DEF = 10;

    typedef logic signed [WI_DEF+WF_DEF-1:0] sample_t;

    // A sum of 2^log2_d samples needs log2_d extra integer bits to never overflow.
    function automatic int acc_width(input int wi, input int wf, input int log2_d);
        return wi + wf + log2_d;
    endfunction

endpackage

// File: rtl/samp_fifo.sv
// Small synchronous sample FIFO; power-of-two depth, count register tells full from empty.
module samp_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = PTRW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/filt_out_decim.sv
// Output stage of the filter cascade: averages blocks of 2^LOG2_D samples into a FIFO.
// Define FILT_ROUND_EN for round-half-up averaging; default build truncates (floor).
module filt_out_decim
    import filt_pkg::*;
#(
    parameter int WI     = WI_DEF,
    parameter int WF     = WF_DEF,
    parameter int LOG2_D = 2,
    parameter int DEPTH  = 4
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WI+WF-1:0] in_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WI+WF-1:0] out_sample,
    output logic                    overflow,
    input  logic                    clr_ovf
);

    localparam int W  = WI + WF;
    localparam int AW = acc_width(WI, WF, LOG2_D);
    localparam int PW = (LOG2_D > 0) ? LOG2_D : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'((1 << LOG2_D) - 1);
`ifdef FILT_ROUND_EN
    // Half an LSB of the shifted result; collapses to zero in pass-through mode.
    localparam logic signed [AW-1:0] ROUND_K = AW'((1 << LOG2_D) >> 1);
`else
    localparam logic signed [AW-1:0] ROUND_K = '0;
`endif

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] samp_ext;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] shifted;
    logic signed [W-1:0]  result;
    logic [PW-1:0]        phase;
    logic                 last;
    logic                 push;
    logic                 pop;
    logic                 drop;
    logic                 full;
    logic                 empty;

    assign samp_ext = AW'(in_sample);
    assign last     = (phase == PHASE_LAST);
    assign push     = in_valid && last;
    assign sum      = acc + samp_ext + ROUND_K;
    assign shifted  = sum >>> LOG2_D;
    assign result   = shifted[W-1:0];

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && full && !pop;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            phase <= '0;
        end else if (in_valid) begin
            if (last) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= acc + samp_ext;
                phase <= phase + PW'(1);
            end
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    samp_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .rst_n (rst_n),
        .push  (push),
        .din   (result),
        .pop   (pop),
        .dout  (out_sample),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_filt_out_decim.sv
// Scoreboard bench for filt_out_decim at default parameters.
module tb_filt_out_decim;
    import filt_pkg::*;

    logic    CLK = 1'b0;
    logic    rst_n;
    logic    in_valid;
    sample_t in_sample;
    logic    out_valid;
    logic    out_ready;
    sample_t out_sample;
    logic    overflow;
    logic    clr_ovf;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int pop_base = 0;
    int exp_q[$];
    int exp_val;
    logic    hold_prev = 1'b0;
    sample_t hold_sample;

`ifdef FILT_ROUND_EN
    localparam int EXP_NEG = -1;
`else
    localparam int EXP_NEG = -2;
`endif

    filt_out_decim dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic apply_stimulus(input logic valid, input int sample, input logic rdy);
        in_valid  = valid;
        in_sample = sample_t'(sample);
        out_ready = rdy;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Monitor: pops the scoreboard on every handshake and checks head stability while stalled.
    always @(negedge CLK) begin
        if (rst_n) begin
            if (hold_prev && out_valid) begin
                check_output("hold_stable", out_sample, hold_sample);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_out: got %0d, expected no output", out_sample);
                end else begin
                    exp_val = exp_q.pop_front();
                    check_output("out_sample", out_sample, exp_val);
                end
                pops++;
            end
            hold_prev   = out_valid && !out_ready;
            hold_sample = out_sample;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_sample", out_sample, 0);
        check_output("rst_overflow", overflow, 0);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Basic average, one-cycle latency
        apply_stimulus(1'b1, 100, 1'b1);
        apply_stimulus(1'b1, 200, 1'b1);
        apply_stimulus(1'b1, 300, 1'b1);
        exp_q.push_back(250);
        apply_stimulus(1'b1, 400, 1'b1);
        @(negedge CLK);
        check_output("latency_valid", out_valid, 1);
        idle(2);
        check_output("basic_overflow", overflow, 0);

        // Negative floor versus round-half-up
        apply_stimulus(1'b1, -1, 1'b1);
        apply_stimulus(1'b1, -1, 1'b1);
        apply_stimulus(1'b1, -1, 1'b1);
        exp_q.push_back(EXP_NEG);
        apply_stimulus(1'b1, -2, 1'b1);
        idle(3);

        // Fill with consumer stalled; fifth result is dropped
        for (int i = 0; i < 20; i++) begin
            if ((i % 4 == 3) && (i < 16)) exp_q.push_back(512);
            apply_stimulus(1'b1, 512, 1'b0);
        end
        check_output("fill_overflow", overflow, 1);
        check_output("fill_valid", out_valid, 1);
        pop_base  = pops;
        out_ready = 1'b1;
        idle(8);
        check_output("drain_count", pops - pop_base, 4);
        check_output("drain_empty", out_valid, 0);
        check_output("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        check_output("ovf_cleared", overflow, 0);

        // Full FIFO with push and pop in the same cycle
        for (int b = 1; b <= 4; b++) begin
            for (int i = 0; i < 4; i++) begin
                if (i == 3) exp_q.push_back(10 * b);
                apply_stimulus(1'b1, 10 * b, 1'b0);
            end
        end
        apply_stimulus(1'b1, 50, 1'b0);
        apply_stimulus(1'b1, 50, 1'b0);
        apply_stimulus(1'b1, 50, 1'b0);
        exp_q.push_back(50);
        apply_stimulus(1'b1, 50, 1'b1);
        out_ready = 1'b0;
        check_output("pushpop_overflow", overflow, 0);
        check_output("pushpop_valid", out_valid, 1);
        pop_base  = pops;
        out_ready = 1'b1;
        idle(8);
        check_output("pushpop_count", pops - pop_base, 4);
        check_output("pushpop_empty", out_valid, 0);

        // Gapped valid at full scale
        apply_stimulus(1'b1, 2047, 1'b1);
        apply_stimulus(1'b0, 1365, 1'b1);
        apply_stimulus(1'b0, -1365, 1'b1);
        apply_stimulus(1'b1, 2047, 1'b1);
        apply_stimulus(1'b1, 2047, 1'b1);
        apply_stimulus(1'b0, 7, 1'b1);
        exp_q.push_back(2047);
        apply_stimulus(1'b1, 2047, 1'b1);
        idle(3);
        check_output("gap_overflow", overflow, 0);

        // Reset in the middle of a block discards the partial sum
        apply_stimulus(1'b1, 100, 1'b1);
        apply_stimulus(1'b1, 100, 1'b1);
        rst_n = 1'b0;
        @(negedge CLK);
        check_output("midrst_valid", out_valid, 0);
        check_output("midrst_sample", out_sample, 0);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(8);
            apply_stimulus(1'b1, 8, 1'b1);
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge CLK);
        idle(2);
        check_output("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
